// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states,
// command FIFO entry layout and ALU error bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;

  localparam int ERR_DBZ = 1;
  localparam int ERR_OVF = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic        chain;
  } entry_t;

  function automatic logic is_legal(input logic [3:0] cmd);
    case (cmd)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request and response channels between bus-side requesters (master) and
// the ALU sequencer (slave).
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_tag;
  logic        req_chain;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic        rsp_illegal;
  logic [3:0]  rsp_tag;

  modport master (
    output req_valid, req_cmd, req_a, req_b, req_tag, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal, rsp_tag
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, req_tag, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal, rsp_tag
  );
endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with registered full/empty flags; DEPTH must be a power
// of two so the pointers wrap naturally.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: the flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the 16-bit combinational ALU: queues requests,
// holds ALU inputs for a settle window, returns result/error. Optional
// accumulator chaining is enabled by defining ALU_SEQ_ACC_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_if.slave     bus,
  output logic [15:0]  alu_a,
  output logic [15:0]  alu_b,
  output logic [3:0]   alu_cmd,
  input  logic [31:0]  alu_result,
  input  logic [1:0]   alu_error,
  output logic         busy
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  err_q, err_d;
  logic        ill_q, ill_d;
  logic [3:0]  tag_q, tag_d;
  logic        pop, fifo_full, fifo_empty;
  logic [$bits(entry_t)-1:0] fifo_dout;
  entry_t      push_entry, head;

  assign push_entry = '{cmd: bus.req_cmd, a: bus.req_a, b: bus.req_b,
                        tag: bus.req_tag, chain: bus.req_chain};
  assign head = entry_t'(fifo_dout);

  alu_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.req_valid),
    .din_i   (push_entry),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty)
  );

`ifdef ALU_SEQ_ACC_EN
  logic [31:0] acc_q, acc_d;
  logic [15:0] acc_hi_unused;
  logic [15:0] op_a;
  assign acc_hi_unused = acc_q[31:16];
  assign op_a = head.chain ? acc_q[15:0] : head.a;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  logic        chain_unused;
  logic [15:0] op_a;
  assign chain_unused = head.chain;
  assign op_a = head.a;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cmd_d = alu_cmd_q;
    res_d     = res_q;
    err_d     = err_q;
    ill_d     = ill_q;
    tag_d     = tag_q;
    pop       = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop   = 1'b1;
        tag_d = head.tag;
        if (is_legal(head.cmd)) begin
          alu_a_d   = op_a;
          alu_b_d   = head.b;
          alu_cmd_d = head.cmd;
          cnt_d     = CW'(SETTLE_CYCLES);
          state_d   = S_WAIT;
        end else begin
          // ALU lines stay untouched; response is synthesised locally
          res_d   = '0;
          err_d   = '0;
          ill_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: if (cnt_q == CW'(1)) begin
        res_d     = alu_result;
        err_d     = {alu_error[ERR_DBZ], alu_error[ERR_OVF]};
        ill_d     = 1'b0;
        alu_cmd_d = OP_NOP;
        state_d   = S_RESP;
`ifdef ALU_SEQ_ACC_EN
        acc_d     = alu_result;
`endif
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cmd_q <= OP_NOP;
      res_q     <= '0;
      err_q     <= '0;
      ill_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cmd_q <= alu_cmd_d;
      res_q     <= res_d;
      err_q     <= err_d;
      ill_q     <= ill_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.req_ready   = !fifo_full;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_result  = res_q;
  assign bus.rsp_error   = err_q;
  assign bus.rsp_illegal = ill_q;
  assign bus.rsp_tag     = tag_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_cmd         = alu_cmd_q;
  assign busy            = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a response
// scoreboard; covers the ALU_SEQ_ACC_EN chaining path when that macro is set.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  err;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        busy;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];

  alu_seq_if bus();

  alu_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {error, result}
  function automatic logic [33:0] alu_model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic [1:0]  e;
    r = '0; e = '0;
    case (c)
      OP_ADD: begin r = {16'h0, a} + {16'h0, b}; e[ERR_OVF] = r[16]; end
      OP_SUB: begin r = {16'h0, a} - {16'h0, b}; e[ERR_OVF] = (a < b); end
      OP_MUL: r = {16'h0, a} * {16'h0, b};
      OP_DIV: if (b == 0) begin r = 32'hFFFF_FFFF; e[ERR_DBZ] = 1'b1; end
              else r = {16'h0, a / b};
      OP_MOD: if (b == 0) begin r = {16'h0, a}; e[ERR_DBZ] = 1'b1; end
              else r = {16'h0, a % b};
      default: ;
    endcase
    return {e, r};
  endfunction

  always_comb {alu_error, alu_result} = alu_model(alu_cmd, alu_a, alu_b);

  function automatic exp_t mk_exp(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    exp_t x;
    logic [33:0] m;
    m = alu_model(c, a, b);
    x.res = (c >= 4'd1 && c <= 4'd5) ? m[31:0] : 32'h0;
    x.err = (c >= 4'd1 && c <= 4'd5) ? m[33:32] : 2'b00;
    x.ill = !(c >= 4'd1 && c <= 4'd5);
    x.tag = t;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold a request until accepted or max_cyc edges pass; returns in the cycle after acceptance.
  task automatic send(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t, input logic ch, input exp_t e, input int max_cyc,
                      output bit ok);
    bit hs;
    ok = 1'b0;
    bus.req_cmd = c; bus.req_a = a; bus.req_b = b; bus.req_tag = t; bus.req_chain = ch;
    bus.req_valid = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      hs = bus.req_ready;
      tick();
      if (hs) begin ok = 1'b1; break; end
    end
    bus.req_valid = 1'b0;
    if (ok) exp_q.push_back(e);
  endtask

  // Wait for rsp_valid, score against the queue head, consume if rsp_ready is high.
  task automatic get_rsp(input string tag, output int lat);
    bit   seen;
    exp_t e;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin seen = 1'b1; break; end
      tick(); lat++;
    end
    chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (seen && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_result"},  bus.rsp_result,       e.res);
      chk({tag, "_error"},   32'(bus.rsp_error),   32'(e.err));
      chk({tag, "_illegal"}, 32'(bus.rsp_illegal), 32'(e.ill));
      chk({tag, "_tag"},     32'(bus.rsp_tag),     32'(e.tag));
    end
    if (bus.rsp_ready) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ok;
    int         lat;
    int         vcnt;
    logic [3:0] c;
    exp_t       e;
    logic [31:0] tp_res [5];

    tp_res[0] = 32'd318; tp_res[1] = 32'd180; tp_res[2] = 32'd17181;
    tp_res[3] = 32'd3;   tp_res[4] = 32'd42;

    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.req_chain = 1'b0; bus.rsp_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Five ops on A=249, B=69; latency from acceptance edge is 2+SETTLE
    for (int i = 0; i < 5; i++) begin
      c = 4'(i + 1);
      e = '{res: tp_res[i], err: 2'b00, ill: 1'b0, tag: 4'(i + 1)};
      send(c, 16'd249, 16'd69, 4'(i + 1), 1'b0, e, 10, ok);
      chk("op_accept", 32'(ok), 32'd1);
      get_rsp("op", lat);
      chk("op_latency", 32'(lat + 1), 32'd4);
    end

    // Divide by zero
    e = '{res: 32'hFFFF_FFFF, err: 2'b10, ill: 1'b0, tag: 4'd6};
    send(OP_DIV, 16'd100, 16'd0, 4'd6, 1'b0, e, 10, ok);
    get_rsp("dbz", lat);

    // Illegal opcode
    e = '{res: 32'd0, err: 2'b00, ill: 1'b1, tag: 4'd9};
    send(4'd7, 16'd1, 16'd2, 4'd9, 1'b0, e, 10, ok);
    chk("ill_alu_cmd_pop", 32'(alu_cmd), 32'd0);
    tick();
    chk("ill_alu_cmd_resp", 32'(alu_cmd), 32'd0);
    chk("ill_valid_cycle2", 32'(bus.rsp_valid), 32'd1);
    get_rsp("ill", lat);
    chk("ill_latency", 32'(lat), 32'd0);

    // Backpressure: 6 back-to-back, 5 accepted
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c = 4'((i % 5) + 1);
      e = mk_exp(c, 16'(1000 + i), 16'(7 + i), 4'(i + 1));
      send(c, 16'(1000 + i), 16'(7 + i), 4'(i + 1), 1'b0, e, 10, ok);
      chk("bp_accept", 32'(ok), 32'd1);
    end
    chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
    e = mk_exp(OP_ADD, 16'd1, 16'd1, 4'd6);
    send(OP_ADD, 16'd1, 16'd1, 4'd6, 1'b0, e, 4, ok);
    chk("bp_6th_rejected", 32'(ok), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) get_rsp("bp", lat);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) vcnt++;
      tick();
    end
    chk("bp_no_extra", 32'(vcnt), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset during WAIT
    e = mk_exp(OP_MUL, 16'd300, 16'd400, 4'd3);
    send(OP_MUL, 16'd300, 16'd400, 4'd3, 1'b0, e, 10, ok);
    tick();
    chk("rw_busy_before", 32'(busy), 32'd1);
    chk("rw_alu_cmd_before", 32'(alu_cmd), 32'(OP_MUL));
    #2 rst = 1'b1;
    #1;
    chk("rw_alu_cmd", 32'(alu_cmd), 32'd0);
    chk("rw_alu_a", 32'(alu_a), 32'd0);
    chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rw_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rw_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) vcnt++;
      tick();
    end
    chk("rw_no_rsp", 32'(vcnt), 32'd0);
    e = mk_exp(OP_SUB, 16'd50, 16'd80, 4'd11);
    send(OP_SUB, 16'd50, 16'd80, 4'd11, 1'b0, e, 10, ok);
    get_rsp("rw_next", lat);
    chk("rw_next_latency", 32'(lat + 1), 32'd4);

`ifdef ALU_SEQ_ACC_EN
    e = '{res: 32'd318, err: 2'b00, ill: 1'b0, tag: 4'd1};
    send(OP_ADD, 16'd249, 16'd69, 4'd1, 1'b0, e, 10, ok);
    get_rsp("acc_first", lat);
    e = '{res: 32'd320, err: 2'b00, ill: 1'b0, tag: 4'd2};
    send(OP_ADD, 16'd0, 16'd2, 4'd2, 1'b1, e, 10, ok);
    get_rsp("acc_chain", lat);
`else
    e = '{res: 32'd11, err: 2'b00, ill: 1'b0, tag: 4'd4};
    send(OP_ADD, 16'd5, 16'd6, 4'd4, 1'b1, e, 10, ok);
    get_rsp("chain_ignored", lat);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
